// File: rtl/wb_merge_unit_pkg.sv
// Shared writeback types: register widths, the late-result entry record and lane helpers.
// The entry record is also used by the hazard unit.
package wb_merge_unit_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef struct packed {
      logic                  live;
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_entry;

   // Writes to $0 never count as activity.
   function automatic logic lane_active(input logic valid, input logic [REG_ADDR_W-1:0] addr);
      return valid && (addr != '0);
   endfunction

   function automatic logic lane_hit(input logic [REG_ADDR_W-1:0] addr,
                                     input logic en_1, input logic [REG_ADDR_W-1:0] addr_1,
                                     input logic en_2, input logic [REG_ADDR_W-1:0] addr_2);
      return (en_1 && (addr == addr_1)) || (en_2 && (addr == addr_2));
   endfunction

endpackage

// File: rtl/wb_merge_unit_if.sv
// Bus bundle for the writeback merge unit: pipe lanes, late-result handshake,
// register-file write ports and FIFO status.
interface wb_merge_unit_if
   import wb_merge_unit_pkg::*;
#(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  p1_valid;
   logic [REG_ADDR_W-1:0] p1_addr;
   logic [REG_DATA_W-1:0] p1_data;
   logic                  p2_valid;
   logic [REG_ADDR_W-1:0] p2_addr;
   logic [REG_DATA_W-1:0] p2_data;

   logic                  late_valid;
   logic                  late_ready;
   logic [REG_ADDR_W-1:0] late_addr;
   logic [REG_DATA_W-1:0] late_data;

   logic                  reg_w_en_1;
   logic [REG_ADDR_W-1:0] reg_w_addr_1;
   logic [REG_DATA_W-1:0] reg_w_data_1;
   logic                  reg_w_en_2;
   logic [REG_ADDR_W-1:0] reg_w_addr_2;
   logic [REG_DATA_W-1:0] reg_w_data_2;

   logic [CNT_W-1:0]      fifo_count;
   logic [DEPTH-1:0]      late_pending;

   modport master (
      output p1_valid, p1_addr, p1_data, p2_valid, p2_addr, p2_data,
      output late_valid, late_addr, late_data,
      input  late_ready,
      input  reg_w_en_1, reg_w_addr_1, reg_w_data_1,
      input  reg_w_en_2, reg_w_addr_2, reg_w_data_2,
      input  fifo_count, late_pending
   );

   modport slave (
      input  p1_valid, p1_addr, p1_data, p2_valid, p2_addr, p2_data,
      input  late_valid, late_addr, late_data,
      output late_ready,
      output reg_w_en_1, reg_w_addr_1, reg_w_data_1,
      output reg_w_en_2, reg_w_addr_2, reg_w_data_2,
      output fifo_count, late_pending
   );

endinterface

// File: rtl/wb_late_fifo.sv
// Late-result FIFO: storage, pointers, count and per-entry kill against the active pipe lanes.
// Head liveness is reported after this cycle's kill so a superseded head is never drained.
module wb_late_fifo
   import wb_merge_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_valid,
   input  logic [REG_ADDR_W-1:0] push_addr,
   input  logic [REG_DATA_W-1:0] push_data,
   input  logic                  kill_en_1,
   input  logic [REG_ADDR_W-1:0] kill_addr_1,
   input  logic                  kill_en_2,
   input  logic [REG_ADDR_W-1:0] kill_addr_2,
   input  logic                  pop,
   output logic                  head_valid,
   output logic                  head_live,
   output wb_entry               head,
   output logic                  ready,
   output logic [CNT_W-1:0]      count,
   output logic [DEPTH-1:0]      pending
);

   wb_entry          mem_q [DEPTH];
   wb_entry          mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   assign head       = mem_q[rd_ptr_q];
   assign head_valid = (count_q != '0);
   assign head_live  = head.live && !lane_hit(head.addr, kill_en_1, kill_addr_1, kill_en_2, kill_addr_2);
   assign ready      = (count_q != CNT_W'(DEPTH));
   assign count      = count_q;

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pending[i] = mem_q[i].live;
      end
   end

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q + CNT_W'(push_valid) - CNT_W'(pop);
      for (int i = 0; i < DEPTH; i++) begin
         if (mem_q[i].live && lane_hit(mem_q[i].addr, kill_en_1, kill_addr_1, kill_en_2, kill_addr_2)) begin
            mem_d[i].live = 1'b0;
         end
      end
      if (pop) begin
         mem_d[rd_ptr_q].live = 1'b0;
         rd_ptr_d             = rd_ptr_q + PTR_W'(1);
      end
      // Push slot differs from the popped slot: a full FIFO cannot push, an empty one cannot pop.
      if (push_valid) begin
         mem_d[wr_ptr_q].live = !lane_hit(push_addr, kill_en_1, kill_addr_1, kill_en_2, kill_addr_2);
         mem_d[wr_ptr_q].addr = push_addr;
         mem_d[wr_ptr_q].data = push_data;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/wb_merge_unit.sv
// Writeback merge: pipe lanes pass straight to their write ports, late results drain
// from the FIFO head into whichever port the pipe leaves idle. All outputs registered.
module wb_merge_unit
   import wb_merge_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   wb_merge_unit_if.slave   bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  act_1, act_2;
   logic                  push, pop;
   logic                  drain_1, drain_2;
   logic                  head_valid, head_live, fifo_ready;
   wb_entry               head;
   logic [CNT_W-1:0]      count;
   logic [DEPTH-1:0]      pending;

   logic                  en_1_q, en_1_d, en_2_q, en_2_d;
   logic [REG_ADDR_W-1:0] addr_1_q, addr_1_d, addr_2_q, addr_2_d;
   logic [REG_DATA_W-1:0] data_1_q, data_1_d, data_2_q, data_2_d;

   assign act_1 = lane_active(bus.p1_valid, bus.p1_addr);
   assign act_2 = lane_active(bus.p2_valid, bus.p2_addr);
   // A late write to $0 completes the handshake but is never stored.
   assign push  = bus.late_valid && fifo_ready && (bus.late_addr != '0);

   wb_late_fifo #(.DEPTH(DEPTH)) u_late_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_valid  (push),
      .push_addr   (bus.late_addr),
      .push_data   (bus.late_data),
      .kill_en_1   (act_1),
      .kill_addr_1 (bus.p1_addr),
      .kill_en_2   (act_2),
      .kill_addr_2 (bus.p2_addr),
      .pop         (pop),
      .head_valid  (head_valid),
      .head_live   (head_live),
      .head        (head),
      .ready       (fifo_ready),
      .count       (count),
      .pending     (pending)
   );

   always_comb begin
      pop     = 1'b0;
      drain_1 = 1'b0;
      drain_2 = 1'b0;
      if (head_valid) begin
         if (!head_live) begin
            pop = 1'b1;
         end else if (!act_1) begin
            drain_1 = 1'b1;
            pop     = 1'b1;
         end else if (!act_2) begin
            drain_2 = 1'b1;
            pop     = 1'b1;
         end
      end
   end

   always_comb begin
      en_1_d   = act_1 || drain_1;
      addr_1_d = '0;
      data_1_d = '0;
      if (act_1) begin
         addr_1_d = bus.p1_addr;
         data_1_d = bus.p1_data;
      end else if (drain_1) begin
         addr_1_d = head.addr;
         data_1_d = head.data;
      end
      en_2_d   = act_2 || drain_2;
      addr_2_d = '0;
      data_2_d = '0;
      if (act_2) begin
         addr_2_d = bus.p2_addr;
         data_2_d = bus.p2_data;
      end else if (drain_2) begin
         addr_2_d = head.addr;
         data_2_d = head.data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_1_q   <= 1'b0;
         addr_1_q <= '0;
         data_1_q <= '0;
         en_2_q   <= 1'b0;
         addr_2_q <= '0;
         data_2_q <= '0;
      end else begin
         en_1_q   <= en_1_d;
         addr_1_q <= addr_1_d;
         data_1_q <= data_1_d;
         en_2_q   <= en_2_d;
         addr_2_q <= addr_2_d;
         data_2_q <= data_2_d;
      end
   end

   assign bus.reg_w_en_1   = en_1_q;
   assign bus.reg_w_addr_1 = addr_1_q;
   assign bus.reg_w_data_1 = data_1_q;
   assign bus.reg_w_en_2   = en_2_q;
   assign bus.reg_w_addr_2 = addr_2_q;
   assign bus.reg_w_data_2 = data_2_q;
   assign bus.late_ready   = fifo_ready;
   assign bus.fifo_count   = count;
   assign bus.late_pending = pending;

endmodule
